// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers, direct writes and flush.
// Define MULDIV_MADD_EN to make op 100/101 accumulate into {hi,lo}; otherwise they act as mult/multu.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  // {remainder, quotient} while dividing, running product while multiplying
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
`ifdef MULDIV_MADD_EN
  logic               acc_q, acc_d;
`endif

  logic               op_rsvd, op_sgn, op_div, start_ok;
  logic [WIDTH:0]     msum, shifted, diff;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [2*WIDTH-1:0] prod_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && (v < 0)) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign op_rsvd  = op[2] & op[1];
  assign op_sgn   = ~op[0];
  assign op_div   = op[1] & ~op[2];
  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign ready    = (state_q == DONE);
  assign start_ok = start && !busy && !op_rsvd;

  // Iteration datapath: one shift-add or one restoring subtract-shift per cycle
  assign msum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
  assign shifted = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb_q};

  // Sign correction; divide-by-zero forces an all-ones quotient regardless of sign
  assign q_fix = div0_q ? '1 : neg_w(prod_q[WIDTH-1:0], neg_res_q);
  assign r_fix = neg_w(prod_q[2*WIDTH-1:WIDTH], neg_rem_q);
`ifdef MULDIV_MADD_EN
  assign prod_fix = neg_2w(prod_q, neg_res_q) + (acc_q ? {hi_q, lo_q} : '0);
`else
  assign prod_fix = neg_2w(prod_q, neg_res_q);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
`ifdef MULDIV_MADD_EN
    acc_d     = acc_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_ok) begin
          state_d   = CALC;
          cnt_d     = CNTW'(WIDTH);
          prod_d    = {{WIDTH{1'b0}}, magnitude(srca, op_sgn)};
          opb_d     = magnitude(srcb, op_sgn);
          is_div_d  = op_div;
          neg_res_d = op_sgn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          neg_rem_d = op_sgn & srca[WIDTH-1];
          div0_d    = op_div && (srcb == '0);
`ifdef MULDIV_MADD_EN
          acc_d     = op[2];
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            if (!diff[WIDTH]) prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            else              prod_d = {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
          end else begin
            prod_d = {msum, prod_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (is_div_q) begin
            hi_d = r_fix;
            lo_d = q_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Direct writes only while idle/done and not launching; DONE results are already in hi_q/lo_q
    if (!busy && !start_ok) begin
      if (write_hi) hi_d = wdata;
      if (write_lo) lo_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    prod_q    <= prod_d;
    opb_q     <= opb_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    div0_q    <= div0_d;
`ifdef MULDIV_MADD_EN
    acc_q     <= acc_d;
`endif
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush, write_hi, write_lo;
  logic [2:0]   op;
  logic [W-1:0] srca, srcb, wdata;
  logic         busy, ready;
  logic [W-1:0] hi, lo;

  int ncmp  = 0;
  int nfail = 0;

  localparam int NDIV = 5;
  localparam logic [2:0]   DOP [NDIV] = '{3'b010, 3'b010, 3'b011, 3'b010, 3'b010};
  localparam logic [W-1:0] DA  [NDIV] = '{32'hFFFFFFF9, 32'h80000000, 32'h00001234,
                                          32'hFFFFFFFB, 32'h00000007};
  localparam logic [W-1:0] DB  [NDIV] = '{32'h00000002, 32'hFFFFFFFF, 32'h00000000,
                                          32'h00000000, 32'hFFFFFFFE};
  localparam logic [W-1:0] DHI [NDIV] = '{32'hFFFFFFFF, 32'h00000000, 32'h00001234,
                                          32'hFFFFFFFB, 32'h00000001};
  localparam logic [W-1:0] DLO [NDIV] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF,
                                          32'hFFFFFFFF, 32'hFFFFFFFD};

  muldiv_unit #(.WIDTH(W), .CNTW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .write_hi(write_hi), .write_lo(write_lo), .wdata(wdata),
    .busy(busy), .ready(ready), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  // Returns at the negedge after the start edge (edge 0)
  task automatic do_start(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n counts edges since the start edge, edge 0 inclusive; bounded at 80
  task automatic wait_ready(input int n0, output int n, output int bcnt);
    n = n0;
    bcnt = busy ? 1 : 0;
    while (!ready && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    op = 3'b000; srca = '0; srcb = '0; wdata = '0;
    #3;
    ncmp++; if (hi !== 32'h0) begin nfail++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
    ncmp++; if (lo !== 32'h0) begin nfail++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
    ncmp++; if (ready !== 1'b0) begin nfail++; $display("FAIL reset_ready: got %b want 0", ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_multu_latency();
    int n, b;
    do_start(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_ready(1, n, b);
    ncmp++; if (n !== 34) begin nfail++; $display("FAIL multu_latency: got %0d want 34", n); end
    ncmp++; if (b !== 33) begin nfail++; $display("FAIL multu_busy_cycles: got %0d want 33", b); end
    ncmp++; if (hi !== 32'hFFFFFFFE) begin nfail++; $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFFFFFE); end
    ncmp++; if (lo !== 32'h00000001) begin nfail++; $display("FAIL multu_lo: got %h want %h", lo, 32'h1); end
    @(posedge clk); #1;
    ncmp++; if (ready !== 1'b0) begin nfail++; $display("FAIL ready_pulse_width: got %b want 0", ready); end
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL idle_after_done: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n, b;
    do_start(3'b000, 32'hFFFFFFFD, 32'h00000005);
    wait_ready(1, n, b);
    ncmp++; if (hi !== 32'hFFFFFFFF) begin nfail++; $display("FAIL mult_neg_hi: got %h want %h", hi, 32'hFFFFFFFF); end
    ncmp++; if (lo !== 32'hFFFFFFF1) begin nfail++; $display("FAIL mult_neg_lo: got %h want %h", lo, 32'hFFFFFFF1); end
    start = 1'b1; op = 3'b011; srca = 32'd100; srcb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    ncmp++; if (busy !== 1'b1) begin nfail++; $display("FAIL b2b_accept: got %b want 1", busy); end
    wait_ready(1, n, b);
    ncmp++; if (n !== 34) begin nfail++; $display("FAIL b2b_latency: got %0d want 34", n); end
    ncmp++; if (lo !== 32'd14) begin nfail++; $display("FAIL divu_lo: got %h want %h", lo, 32'd14); end
    ncmp++; if (hi !== 32'd2) begin nfail++; $display("FAIL divu_hi: got %h want %h", hi, 32'd2); end
  endtask

  task automatic test_divide();
    int n, b;
    for (int i = 0; i < NDIV; i++) begin
      do_start(DOP[i], DA[i], DB[i]);
      wait_ready(1, n, b);
      ncmp++; if (n !== 34) begin nfail++; $display("FAIL div%0d_latency: got %0d want 34", i, n); end
      ncmp++; if (lo !== DLO[i]) begin nfail++; $display("FAIL div%0d_lo: got %h want %h", i, lo, DLO[i]); end
      ncmp++; if (hi !== DHI[i]) begin nfail++; $display("FAIL div%0d_hi: got %h want %h", i, hi, DHI[i]); end
    end
  endtask

  task automatic test_flush();
    int rcnt;
    @(negedge clk); write_hi = 1'b1; wdata = 32'h0000AAAA;
    @(negedge clk); write_hi = 1'b0; write_lo = 1'b1; wdata = 32'h00005555;
    @(negedge clk); write_lo = 1'b0;
    ncmp++; if (hi !== 32'h0000AAAA) begin nfail++; $display("FAIL mthi: got %h want %h", hi, 32'hAAAA); end
    ncmp++; if (lo !== 32'h00005555) begin nfail++; $display("FAIL mtlo: got %h want %h", lo, 32'h5555); end
    do_start(3'b000, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL flush_busy: got %b want 0", busy); end
    @(negedge clk); flush = 1'b0;
    rcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (ready) rcnt++; end
    ncmp++; if (rcnt !== 0) begin nfail++; $display("FAIL flush_no_ready: got %0d want 0", rcnt); end
    ncmp++; if (hi !== 32'h0000AAAA) begin nfail++; $display("FAIL flush_hi: got %h want %h", hi, 32'hAAAA); end
    ncmp++; if (lo !== 32'h00005555) begin nfail++; $display("FAIL flush_lo: got %h want %h", lo, 32'h5555); end
  endtask

  task automatic test_reset_abort();
    int rcnt;
    do_start(3'b000, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    ncmp++; if (hi !== 32'h0) begin nfail++; $display("FAIL abort_hi: got %h want %h", hi, 32'h0); end
    ncmp++; if (lo !== 32'h0) begin nfail++; $display("FAIL abort_lo: got %h want %h", lo, 32'h0); end
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL abort_busy: got %b want 0", busy); end
    @(negedge clk); reset = 1'b1;
    rcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (ready || busy) rcnt++; end
    ncmp++; if (rcnt !== 0) begin nfail++; $display("FAIL abort_quiet: got %0d want 0", rcnt); end
  endtask

  task automatic test_ignored();
    int n, b, cnt;
    do_start(3'b001, 32'd6, 32'd7);
    @(negedge clk);
    start = 1'b1; op = 3'b011; srca = 32'd99; srcb = 32'd3; write_lo = 1'b1; wdata = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0; write_lo = 1'b0;
    wait_ready(3, n, b);
    ncmp++; if (n !== 34) begin nfail++; $display("FAIL ignored_latency: got %0d want 34", n); end
    ncmp++; if (lo !== 32'd42) begin nfail++; $display("FAIL ignored_lo: got %h want %h", lo, 32'd42); end
    ncmp++; if (hi !== 32'd0) begin nfail++; $display("FAIL ignored_hi: got %h want %h", hi, 32'd0); end
    @(posedge clk); #1;
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL ignored_start_dropped: got %b want 0", busy); end
    @(negedge clk); start = 1'b1; op = 3'b110;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    repeat (10) begin @(posedge clk); #1; if (ready || busy) cnt++; end
    ncmp++; if (cnt !== 0) begin nfail++; $display("FAIL reserved_op: got %0d want 0", cnt); end
    ncmp++; if (lo !== 32'd42) begin nfail++; $display("FAIL reserved_lo: got %h want %h", lo, 32'd42); end
  endtask

  task automatic test_write_rules();
    int n, b;
    @(negedge clk); write_hi = 1'b1; write_lo = 1'b1; wdata = 32'h12345678;
    @(negedge clk); write_hi = 1'b0; write_lo = 1'b0;
    ncmp++; if (hi !== 32'h12345678) begin nfail++; $display("FAIL dual_write_hi: got %h want %h", hi, 32'h12345678); end
    ncmp++; if (lo !== 32'h12345678) begin nfail++; $display("FAIL dual_write_lo: got %h want %h", lo, 32'h12345678); end
    @(negedge clk);
    start = 1'b1; op = 3'b001; srca = 32'd2; srcb = 32'd3; write_hi = 1'b1; wdata = 32'hFFFF0000;
    @(posedge clk); #1;
    start = 1'b0; write_hi = 1'b0;
    ncmp++; if (hi !== 32'h12345678) begin nfail++; $display("FAIL write_with_start: got %h want %h", hi, 32'h12345678); end
    wait_ready(1, n, b);
    ncmp++; if (lo !== 32'd6) begin nfail++; $display("FAIL wr_mul_lo: got %h want %h", lo, 32'd6); end
    write_hi = 1'b1; wdata = 32'h00000077;
    @(posedge clk); #1;
    write_hi = 1'b0;
    ncmp++; if (hi !== 32'h00000077) begin nfail++; $display("FAIL done_write_wins: got %h want %h", hi, 32'h77); end
    ncmp++; if (lo !== 32'd6) begin nfail++; $display("FAIL done_write_lo_kept: got %h want %h", lo, 32'd6); end
  endtask

  task automatic test_madd();
    int n, b;
    logic [W-1:0] exp_hi, exp_lo;
`ifdef MULDIV_MADD_EN
    exp_hi = 32'h1; exp_lo = 32'h0;
`else
    exp_hi = 32'h0; exp_lo = 32'h1;
`endif
    @(negedge clk); write_hi = 1'b1; wdata = 32'h0;
    @(negedge clk); write_hi = 1'b0; write_lo = 1'b1; wdata = 32'hFFFFFFFF;
    @(negedge clk); write_lo = 1'b0;
    do_start(3'b101, 32'd1, 32'd1);
    wait_ready(1, n, b);
    ncmp++; if (n !== 34) begin nfail++; $display("FAIL maddu_latency: got %0d want 34", n); end
    ncmp++; if (hi !== exp_hi) begin nfail++; $display("FAIL maddu_hi: got %h want %h", hi, exp_hi); end
    ncmp++; if (lo !== exp_lo) begin nfail++; $display("FAIL maddu_lo: got %h want %h", lo, exp_lo); end
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_back_to_back();
    test_divide();
    test_flush();
    test_reset_abort();
    test_ignored();
    test_write_rules();
    test_madd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
